// File: rtl/point_serializer_pkg.sv
// point_serializer_pkg
//   Shared types and constants for the translate -> serialize point path.
//   COORD_WIDTH / POINTS are the default geometry; point_t and vec_t are the
//   packed layouts both stages agree on. In vec_t, element POINTS-1 occupies
//   the MSBs and is therefore point 0 of the vector.
package point_serializer_pkg;

    localparam int COORD_WIDTH = 16;
    localparam int POINTS      = 4;

    typedef struct packed {
        logic [COORD_WIDTH-1:0] x;
        logic [COORD_WIDTH-1:0] y;
    } point_t;

    typedef point_t [POINTS-1:0] vec_t;

    // $clog2 that never returns 0, so counters/pointers keep at least one bit
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vec_fifo.sv
// vec_fifo
//   DEPTH-entry circular FIFO of WIDTH-bit vectors with wrapping pointers.
//   Ports:
//     clk, rst_n        clock, synchronous active-low reset (pointers/count)
//     push, push_data   write request; ignored while full
//     pop               retire head entry; ignored while empty
//     full, empty       occupancy flags from the registered count
//     head              current head entry (storage is not reset)
module vec_fifo
    import point_serializer_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = clog2_min1(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            // push and pop together leave the occupancy unchanged
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/point_serializer.sv
// point_serializer
//   Buffers packed point vectors and emits them one (x,y) point per transfer,
//   point 0 (MSBs of the vector) first.
//   Ports:
//     clk_in, rst_in          clock, synchronous active-low reset
//     data_in, valid_in       input vector and its valid
//     ready_out               space available (registered-state only)
//     x_out, y_out, last_out  current point; last_out marks point POINTS-1
//     valid_out, ready_in     output handshake
module point_serializer
    import point_serializer_pkg::*;
#(
    parameter int COORD_WIDTH = point_serializer_pkg::COORD_WIDTH,
    parameter int POINTS      = point_serializer_pkg::POINTS,
    parameter int DEPTH       = 2
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [2*COORD_WIDTH*POINTS-1:0] data_in,
    input  logic                          valid_in,
    output logic                          ready_out,
    output logic [COORD_WIDTH-1:0]        x_out,
    output logic [COORD_WIDTH-1:0]        y_out,
    output logic                          last_out,
    output logic                          valid_out,
    input  logic                          ready_in
);

    localparam int PTW = 2 * COORD_WIDTH;
    localparam int VW  = PTW * POINTS;
    localparam int LW  = clog2_min1(POINTS);

    logic [LW-1:0]  lane;
    logic           lane_last;
    logic           full;
    logic           empty;
    logic [VW-1:0]  head;
    logic [PTW-1:0] cur_pt;
    logic           push;
    logic           xfer;
    logic           pop;

    vec_fifo #(
        .WIDTH (VW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk_in),
        .rst_n     (rst_in),
        .push      (push),
        .push_data (data_in),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .head      (head)
    );

    assign ready_out = ~full;
    assign valid_out = ~empty;
    assign push      = valid_in & ready_out;
    assign xfer      = valid_out & ready_in;
    assign lane_last = (lane == LW'(POINTS - 1));
    // the head vector retires together with its final point
    assign pop       = xfer & lane_last;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            lane <= '0;
        end else if (xfer) begin
            lane <= lane_last ? '0 : lane + LW'(1);
        end
    end

    // point k sits at the top of the vector minus k slots
    always_comb begin
        cur_pt = head[(POINTS - 1 - int'(lane)) * PTW +: PTW];
    end

    // storage is not reset, so gate the data while nothing is buffered
    assign x_out    = valid_out ? cur_pt[PTW-1 -: COORD_WIDTH] : '0;
    assign y_out    = valid_out ? cur_pt[COORD_WIDTH-1:0]      : '0;
    assign last_out = valid_out & lane_last;

endmodule

// File: tb/tb_point_serializer.sv
// tb_point_serializer
//   Directed bench for point_serializer. Inputs change and outputs are
//   sampled on the falling edge; the DUT updates on the rising edge.
module tb_point_serializer;

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic [127:0] data_in;
    logic         valid_in;
    logic         ready_out;
    logic [15:0]  x_out;
    logic [15:0]  y_out;
    logic         last_out;
    logic         valid_out;
    logic         ready_in;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [127:0] V1 = 128'h0003_0004_0005_0006_0007_0008_0009_000A;
    localparam logic [127:0] V2 = 128'h0011_0012_0013_0014_0015_0016_0017_0018;
    localparam logic [127:0] VA = 128'h0021_0022_0023_0024_0025_0026_0027_0028;
    localparam logic [127:0] VB = 128'h0031_0032_0033_0034_0035_0036_0037_0038;
    localparam logic [127:0] VC = 128'h0041_0042_0043_0044_0045_0046_0047_0048;
    localparam logic [127:0] VD = 128'h0051_0052_0053_0054_0055_0056_0057_0058;
    localparam logic [127:0] VE = 128'h0061_0062_0063_0064_0065_0066_0067_0068;
    localparam logic [127:0] VF = 128'h0071_0072_0073_0074_0075_0076_0077_0078;
    localparam logic [127:0] VG = 128'h0081_0082_0083_0084_0085_0086_0087_0088;

    always #5 clk_in = ~clk_in;

    point_serializer dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .x_out     (x_out),
        .y_out     (y_out),
        .last_out  (last_out),
        .valid_out (valid_out),
        .ready_in  (ready_in)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk_in);
    endtask

    task automatic expect_pt(input string tag, input logic [15:0] x, input logic [15:0] y,
                             input logic last);
        chk({tag, ".valid"}, 32'(valid_out), 32'd1);
        chk({tag, ".x"},     32'(x_out),     32'(x));
        chk({tag, ".y"},     32'(y_out),     32'(y));
        chk({tag, ".last"},  32'(last_out),  32'(last));
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, ".valid"}, 32'(valid_out), 32'd0);
        chk({tag, ".last"},  32'(last_out),  32'd0);
    endtask

    // hand vectors above hold consecutive values: point k = (base+2k, base+2k+1)
    task automatic drain(input string tag, input logic [15:0] base);
        for (int k = 0; k < 4; k++) begin
            expect_pt(tag, 16'(base + 16'(2 * k)), 16'(base + 16'(2 * k + 1)), k == 3);
            tick;
        end
    endtask

    function automatic logic [15:0] tp_x(input int v, input int k);
        return {8'(v), 8'(2 * k)};
    endfunction

    function automatic logic [15:0] tp_y(input int v, input int k);
        return {8'(v), 8'(2 * k + 1)};
    endfunction

    function automatic logic [127:0] tp_vec(input int v);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) r[127 - 32 * k -: 32] = {tp_x(v, k), tp_y(v, k)};
        return r;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in   = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b0;
        data_in  = '0;
        tick;
        tick;

        // reset state
        chk("rst.valid", 32'(valid_out), 32'd0);
        chk("rst.ready", 32'(ready_out), 32'd1);
        chk("rst.last",  32'(last_out),  32'd0);
        chk("rst.x",     32'(x_out),     32'd0);
        chk("rst.y",     32'(y_out),     32'd0);
        rst_in = 1'b1;

        // single vector, next-cycle latency, last only on point 3
        data_in = V1; valid_in = 1'b1; ready_in = 1'b1;
        tick;
        valid_in = 1'b0;
        drain("single", 16'h0003);
        expect_idle("single.idle");

        // backpressure on point 1 for 5 cycles
        data_in = V2; valid_in = 1'b1;
        tick;
        valid_in = 1'b0;
        expect_pt("bp.p0", 16'h11, 16'h12, 1'b0);
        tick;
        expect_pt("bp.p1", 16'h13, 16'h14, 1'b0);
        ready_in = 1'b0;
        repeat (5) begin
            tick;
            expect_pt("bp.hold", 16'h13, 16'h14, 1'b0);
        end
        ready_in = 1'b1;
        tick;
        expect_pt("bp.p2", 16'h15, 16'h16, 1'b0);
        tick;
        expect_pt("bp.p3", 16'h17, 16'h18, 1'b1);
        tick;
        expect_idle("bp.idle");

        // full: third vector waits until vector A drains
        ready_in = 1'b0;
        chk("full.rdy0", 32'(ready_out), 32'd1);
        data_in = VA; valid_in = 1'b1;
        tick;
        chk("full.rdy1", 32'(ready_out), 32'd1);
        data_in = VB;
        tick;
        chk("full.rdy2", 32'(ready_out), 32'd0);
        data_in = VC;
        tick;
        chk("full.rdy3", 32'(ready_out), 32'd0);
        expect_pt("full.a0", 16'h21, 16'h22, 1'b0);
        ready_in = 1'b1;
        tick;
        chk("full.rdy_a1", 32'(ready_out), 32'd0);
        expect_pt("full.a1", 16'h23, 16'h24, 1'b0);
        tick;
        chk("full.rdy_a2", 32'(ready_out), 32'd0);
        expect_pt("full.a2", 16'h25, 16'h26, 1'b0);
        tick;
        chk("full.rdy_a3", 32'(ready_out), 32'd0);
        expect_pt("full.a3", 16'h27, 16'h28, 1'b1);
        tick;
        chk("full.rdy_b0", 32'(ready_out), 32'd1);
        expect_pt("full.b0", 16'h31, 16'h32, 1'b0);
        tick;
        valid_in = 1'b0;
        chk("full.rdy_b1", 32'(ready_out), 32'd0);
        expect_pt("full.b1", 16'h33, 16'h34, 1'b0);
        tick;
        expect_pt("full.b2", 16'h35, 16'h36, 1'b0);
        tick;
        expect_pt("full.b3", 16'h37, 16'h38, 1'b1);
        tick;
        chk("full.rdy_c0", 32'(ready_out), 32'd1);
        drain("full.c", 16'h0041);
        expect_idle("full.idle");

        // push in the same cycle as the final-point pop
        data_in = VD; valid_in = 1'b1;
        tick;
        valid_in = 1'b0;
        expect_pt("sim.d0", 16'h51, 16'h52, 1'b0);
        tick;
        expect_pt("sim.d1", 16'h53, 16'h54, 1'b0);
        tick;
        expect_pt("sim.d2", 16'h55, 16'h56, 1'b0);
        tick;
        expect_pt("sim.d3", 16'h57, 16'h58, 1'b1);
        data_in = VE; valid_in = 1'b1;
        tick;
        valid_in = 1'b0;
        chk("sim.rdy", 32'(ready_out), 32'd1);
        drain("sim.e", 16'h0061);
        expect_idle("sim.idle");

        // reset mid-vector discards the rest of vector F
        data_in = VF; valid_in = 1'b1;
        tick;
        valid_in = 1'b0;
        expect_pt("mrst.f0", 16'h71, 16'h72, 1'b0);
        tick;
        expect_pt("mrst.f1", 16'h73, 16'h74, 1'b0);
        rst_in = 1'b0;
        tick;
        rst_in = 1'b1;
        chk("mrst.valid", 32'(valid_out), 32'd0);
        chk("mrst.ready", 32'(ready_out), 32'd1);
        chk("mrst.x",     32'(x_out),     32'd0);
        chk("mrst.last",  32'(last_out),  32'd0);
        data_in = VG; valid_in = 1'b1;
        tick;
        valid_in = 1'b0;
        drain("mrst.g", 16'h0081);
        expect_idle("mrst.idle");

        // throughput: 10 vectors, 40 points with no bubbles
        fork
            begin
                for (int v = 0; v < 10; v++) begin
                    automatic int guard;
                    guard    = 0;
                    data_in  = tp_vec(v);
                    valid_in = 1'b1;
                    while (!ready_out && guard < 50) begin
                        tick;
                        guard++;
                    end
                    if (guard >= 50) chk("tp.push_timeout", 32'(ready_out), 32'd1);
                    tick;
                end
                valid_in = 1'b0;
            end
            begin
                automatic int guard;
                guard = 0;
                while (!valid_out && guard < 20) begin
                    tick;
                    guard++;
                end
                chk("tp.start", 32'(valid_out), 32'd1);
                for (int i = 0; i < 40; i++) begin
                    expect_pt("tp", tp_x(i / 4, i % 4), tp_y(i / 4, i % 4), (i % 4) == 3);
                    tick;
                end
                expect_idle("tp.idle");
            end
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/point_serializer.md
POINT_SERIALIZER -- requirements
Module: point_serializer

Interface
REQ-001 Parameter COORD_WIDTH, default 16: width of one coordinate.
REQ-002 Parameter POINTS, default 4: (x,y) points per input vector; input width is 2*COORD_WIDTH*POINTS (128 by default).
REQ-003 Parameter DEPTH, default 2: number of input vectors the block can buffer.
REQ-004 clk_in  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_in  input  1  reset, synchronous, active-low.
REQ-006 data_in  input  128  packed vector from the translate stage; point k is data_in[127-32k -: 32], x in the upper 16 bits, y in the lower 16.
REQ-007 valid_in  input  1  data_in is valid this cycle.
REQ-008 ready_out  output  1  block can accept a vector this cycle.
REQ-009 x_out  output  16  x coordinate of the current point.
REQ-010 y_out  output  16  y coordinate of the current point.
REQ-011 last_out  output  1  current point is point POINTS-1 of its vector.
REQ-012 valid_out  output  1  x_out, y_out and last_out are valid.
REQ-013 ready_in  input  1  downstream consumer accepts the current point.

Function
REQ-014 Input handshake: a vector SHALL be accepted in a cycle where valid_in and ready_out are both high.
REQ-015 ready_out SHALL equal (stored vector count < DEPTH).
- It is driven from registered state only, with no combinational path from ready_in.
REQ-016 Accepted vectors SHALL be stored in a DEPTH-entry circular FIFO with write/read pointers that wrap modulo DEPTH.
REQ-017 Output handshake: a point SHALL transfer in a cycle where valid_out and ready_in are both high.
REQ-018 Output ordering:
- Points SHALL be emitted in index order 0..POINTS-1 from the FIFO head vector.
- A lane counter selects the point and increments on each output transfer.
REQ-019 Vector retirement: on the transfer of point POINTS-1, the lane counter SHALL wrap to 0 and the head entry SHALL be popped.
REQ-020 valid_out SHALL be high exactly when the FIFO is non-empty.
REQ-021 Outputs SHALL be combinational from the head entry and the lane counter.
REQ-022 Latency: a vector accepted in cycle N SHALL present point 0 with valid_out high in cycle N+1 if the FIFO was empty.
REQ-023 Sustained throughput SHALL be one point per cycle while ready_in is held high.
REQ-024 Stall: while valid_out is high and ready_in is low, x_out, y_out, last_out and the lane counter SHALL hold.
REQ-025 Simultaneous push and final-point pop in one cycle SHALL leave the count unchanged and keep both vectors correct.
REQ-026 When full, ready_out SHALL be low.
- Any valid_in in that cycle SHALL be ignored; the upstream stage holds its data.
- ready_out rises the cycle after the pop.
REQ-027 When empty: valid_out SHALL be 0 and ready_in SHALL be ignored.
REQ-028 Coordinates SHALL pass through unmodified; the block does no arithmetic on data.

Reset
REQ-029 While rst_in is low at a clock edge, count, pointers and lane counter SHALL clear to 0.
- Resulting outputs: valid_out=0, ready_out=1, last_out=0, x_out=0, y_out=0.
REQ-030 Reset mid-vector SHALL discard all buffered points; no partial vector is emitted after reset.
REQ-031 FIFO storage contents need not be reset.

Structure
REQ-032 A shared package SHALL hold:
- COORD_WIDTH and POINTS;
- the packed point typedef (x, y);
- the vector typedef (array of POINTS points).
The translate stage uses the same package.
REQ-033 The FIFO SHALL be one sub-module, vec_fifo, parameterised on width and DEPTH.
- Interface: push/pop, full/empty, head.
- The lane counter and point select stay in point_serializer.

Verification
REQ-034 Single vector: inject 00030004_00050006_00070008_0009000A with ready_in=1.
- Next 4 cycles emit (3,4),(5,6),(7,8),(9,A).
- last_out is high only on (9,A); valid_out is 0 afterwards.
REQ-035 Backpressure: hold ready_in=0 for 5 cycles after point 1 is presented.
- Point 1 stays stable; resuming then yields points 2,3 with no loss or duplication.
REQ-036 Full: push 3 vectors back-to-back with ready_in=0.
- ready_out drops after 2 accepts; the third is accepted only after vector 0 fully drains.
- Output order is preserved.
REQ-037 Simultaneous: with 1 vector stored and lane=3, push a new vector while point 3 transfers.
- Count stays 1; the next cycle emits point 0 of the new vector.
REQ-038 Reset mid-vector: assert rst_in low after point 1 of a stored vector.
- Next cycle valid_out=0 and ready_out=1; a fresh vector then starts at point 0.
REQ-039 Throughput: 10 back-to-back vectors with ready_in=1 produce 40 consecutive valid points with no bubbles after the first.
